// File: rtl/lvseq_pkg.sv
// lvseq_pkg: shared definitions for level_sequencer.
// Contains the state encoding, the per-level palette and the win-screen color.
package lvseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_TRANS = 2'd2,
    ST_DONE  = 2'd3
  } lvseq_state_t;

  // Plain-vector views of the encoding, for code that keeps state in a logic vector.
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_PLAY  = ST_PLAY;
  localparam logic [1:0] S_TRANS = ST_TRANS;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam int PAL_DEPTH = 8;

  // 12-bit RGB palettes; up to PAL_DEPTH levels are supported.
  localparam logic [11:0] LV_TOP [PAL_DEPTH] = '{
    12'h00F, 12'h0F0, 12'hF00, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'h888
  };
  localparam logic [11:0] LV_MID [PAL_DEPTH] = '{
    12'h008, 12'h080, 12'h800, 12'h880, 12'h088, 12'h808, 12'h888, 12'h444
  };

  localparam logic [3:0] WIN_COLOR = 4'hC;

  function automatic logic [11:0] lv_top(input logic [2:0] idx);
    return LV_TOP[idx];
  endfunction

  function automatic logic [11:0] lv_mid(input logic [2:0] idx);
    return LV_MID[idx];
  endfunction

endpackage

// File: rtl/level_sequencer_frame_timer.sv
// frame_timer: saturating counter that advances on each end-of-frame pulse.
// Synchronous active-low reset; clear has priority over increment.
module frame_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller selecting the active level, its palette and pixel color.
// Define LVSEQ_FADE_EN to fade the finished level's pixels out during transitions (default: black).
module level_sequencer
  import lvseq_pkg::*;
#(
  parameter int NUM_LV      = 4,
  parameter int cA          = 4,
  parameter int HOLD_FRAMES = 32,
  parameter int FADE_DIV    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               imgReturn,
  input  logic                               space,
  input  logic [NUM_LV-1:0]                  LVcp,
  input  logic [NUM_LV-1:0][2:0][cA-1:0]     lvColor,
  output logic [NUM_LV-1:0]                  lvRst,
  output logic [11:0]                        topColor,
  output logic [11:0]                        midColor,
  output logic [2:0][cA-1:0]                 color,
  output logic [$clog2(NUM_LV)-1:0]          lvSel,
  output logic [15:0]                        playFrames
);

  localparam int SW = $clog2(NUM_LV);
  localparam int FW = $clog2(HOLD_FRAMES) + 1;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [SW-1:0]     sel_n;
  logic [NUM_LV-1:0] lv_rst_next;
  logic [FW-1:0]     fcnt;
  logic              hold_done;
  logic              enter_play;
  logic              enter_trans;

  assign hold_done   = imgReturn && (fcnt == FW'(HOLD_FRAMES - 1));
  assign enter_play  = (state_n == S_PLAY)  && (state != S_PLAY);
  assign enter_trans = (state_n == S_TRANS) && (state != S_TRANS);

  always_comb begin
    state_n = state;
    sel_n   = lvSel;
    case (state)
      S_IDLE: begin
        if (space) begin
          state_n = S_PLAY;
          sel_n   = '0;
        end
      end
      S_PLAY: begin
        if (LVcp[lvSel]) begin
          state_n = S_TRANS;
        end
      end
      S_TRANS: begin
        if (hold_done) begin
          if (lvSel == SW'(NUM_LV - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_PLAY;
            sel_n   = lvSel + SW'(1);
          end
        end
      end
      S_DONE: begin
        if (space) begin
          state_n = S_IDLE;
          sel_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        sel_n   = '0;
      end
    endcase
  end

  // Only the level about to be active is released, so it always restarts with LVcp low.
  always_comb begin
    lv_rst_next = '0;
    if ((state_n == S_PLAY) || (state_n == S_TRANS)) begin
      lv_rst_next[sel_n] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      lvSel    <= '0;
      lvRst    <= '0;
      topColor <= lv_top(3'd0);
      midColor <= lv_mid(3'd0);
    end else begin
      state    <= state_n;
      lvSel    <= sel_n;
      lvRst    <= lv_rst_next;
      topColor <= lv_top(3'(sel_n));
      midColor <= lv_mid(3'(sel_n));
    end
  end

  frame_timer #(.W(FW)) u_trans_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_trans),
    .inc   (imgReturn && (state == S_TRANS)),
    .count (fcnt)
  );

  frame_timer #(.W(16)) u_play_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_play),
    .inc   (imgReturn && (state == S_PLAY)),
    .count (playFrames)
  );

`ifdef LVSEQ_FADE_EN
  logic [FW-1:0] fade_step;
  logic [FW-1:0] fade_shift;

  always_comb begin
    fade_step  = fcnt / FW'(FADE_DIV);
    fade_shift = (fade_step > FW'(cA)) ? FW'(cA) : fade_step;
  end
`endif

  // Combinational so the pixel path adds no latency behind the level modules.
  always_comb begin
    color = '0;
    case (state)
      S_PLAY: begin
        color = lvColor[lvSel];
      end
      S_TRANS: begin
`ifdef LVSEQ_FADE_EN
        for (int c = 0; c < 3; c++) begin
          color[c] = lvColor[lvSel][c] >> fade_shift;
        end
`endif
      end
      S_DONE: begin
        for (int c = 0; c < 3; c++) begin
          color[c] = cA'(WIN_COLOR);
        end
      end
      default: begin
        color = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed and randomized checks of level_sequencer against a frame-counting model.
// Honours LVSEQ_FADE_EN the same way as the design.
module tb_level_sequencer;

  localparam int NUM_LV = 4;
  localparam int CA     = 4;
  localparam int HOLD   = 32;
  localparam int FDIV   = 8;

  localparam logic [11:0] TOP_TAB [NUM_LV] = '{12'h00F, 12'h0F0, 12'hF00, 12'hFF0};
  localparam logic [11:0] MID_TAB [NUM_LV] = '{12'h008, 12'h080, 12'h800, 12'h880};
  localparam logic [3:0]  WIN = 4'hC;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_TRANS = 2;
  localparam int M_DONE  = 3;

`ifdef LVSEQ_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      imgReturn;
  logic                      space;
  logic [NUM_LV-1:0]         LVcp;
  logic [NUM_LV-1:0][2:0][3:0] lvColor;
  logic [NUM_LV-1:0]         lvRst;
  logic [11:0]               topColor;
  logic [11:0]               midColor;
  logic [2:0][3:0]           color;
  logic [1:0]                lvSel;
  logic [15:0]               playFrames;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: mode, level index, frames counted in the current level and in the transition.
  int mMode  = M_IDLE;
  int mLevel = 0;
  int mPlay  = 0;
  int mTrans = 0;
  bit randColor = 1'b0;

  logic       rA;
  logic       spA;
  logic       irA;
  logic [3:0] cpA;

  always #5 clk = ~clk;

  level_sequencer #(
    .NUM_LV(NUM_LV), .cA(CA), .HOLD_FRAMES(HOLD), .FADE_DIV(FDIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imgReturn  (imgReturn),
    .space      (space),
    .LVcp       (LVcp),
    .lvColor    (lvColor),
    .lvRst      (lvRst),
    .topColor   (topColor),
    .midColor   (midColor),
    .color      (color),
    .lvSel      (lvSel),
    .playFrames (playFrames)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] expColor();
    logic [11:0] r;
    r = 12'h000;
    case (mMode)
      M_PLAY:  r = lvColor[mLevel];
      M_TRANS: begin
        if (FADE) begin
          int sh;
          sh = mTrans / FDIV;
          if (sh > CA) sh = CA;
          for (int c = 0; c < 3; c++) r[c*4 +: 4] = 4'(lvColor[mLevel][c] >> sh);
        end
      end
      M_DONE:  r = {WIN, WIN, WIN};
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  task automatic checkOutput();
    logic [3:0] expRst;
    expRst = ((mMode == M_PLAY) || (mMode == M_TRANS)) ? 4'(1 << mLevel) : 4'b0000;
    checkVal("model_lvSel",      32'(lvSel),      32'(mLevel));
    checkVal("model_lvRst",      32'(lvRst),      32'(expRst));
    checkVal("model_topColor",   32'(topColor),   32'(TOP_TAB[mLevel]));
    checkVal("model_midColor",   32'(midColor),   32'(MID_TAB[mLevel]));
    checkVal("model_playFrames", 32'(playFrames), 32'(mPlay));
    checkVal("model_color",      32'(color),      32'(expColor()));
  endtask

  task automatic modelUpdate();
    if (!rst) begin
      mMode = M_IDLE; mLevel = 0; mPlay = 0; mTrans = 0;
    end else begin
      case (mMode)
        M_IDLE: if (space) begin
          mMode = M_PLAY; mLevel = 0; mPlay = 0;
        end
        M_PLAY: begin
          if (imgReturn && (mPlay < 65535)) mPlay++;
          if (LVcp[mLevel]) begin
            mMode = M_TRANS; mTrans = 0;
          end
        end
        M_TRANS: if (imgReturn) begin
          mTrans++;
          if (mTrans == HOLD) begin
            if (mLevel == NUM_LV - 1) begin
              mMode = M_DONE;
            end else begin
              mLevel++; mPlay = 0; mMode = M_PLAY;
            end
          end
        end
        M_DONE: if (space) begin
          mMode = M_IDLE; mLevel = 0;
        end
        default: mMode = M_IDLE;
      endcase
    end
  endtask

  // Called just after a falling edge: drive, compare, then advance model across the rising edge.
  task automatic applyStimulus(input logic r, input logic sp, input logic ir, input logic [3:0] cp);
    rst = r; space = sp; imgReturn = ir; LVcp = cp;
    if (randColor) lvColor = 48'({$urandom, $urandom});
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic finishLevel(input int lv);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'(1 << lv));
    repeat (HOLD) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    end
  endtask

  initial begin
    rst = 1'b0; space = 1'b0; imgReturn = 1'b0; LVcp = '0;
    lvColor = {12'h963, 12'h48C, 12'h5A3, 12'hFFF};
    repeat (2) @(posedge clk);
    @(negedge clk);

    checkVal("reset_lvSel",      32'(lvSel),      32'd0);
    checkVal("reset_lvRst",      32'(lvRst),      32'h0);
    checkVal("reset_topColor",   32'(topColor),   32'h00F);
    checkVal("reset_midColor",   32'(midColor),   32'h008);
    checkVal("reset_playFrames", 32'(playFrames), 32'd0);
    checkVal("reset_color",      32'(color),      32'h000);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkVal("start_lvSel", 32'(lvSel), 32'd0);
    checkVal("start_lvRst", 32'(lvRst), 32'h1);
    checkVal("start_color", 32'(color), 32'hFFF);

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkVal("play_frames3", 32'(playFrames), 32'd3);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100);
    checkVal("other_cp_lvRst", 32'(lvRst), 32'h1);
    checkVal("other_cp_color", 32'(color), 32'hFFF);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001);
    checkVal("trans_lvRst",  32'(lvRst), 32'h1);
    checkVal("trans0_color", 32'(color), FADE ? 32'hFFF : 32'h000);

    for (int k = 1; k <= HOLD; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      if (k == 8)  checkVal("trans8_color",  32'(color), FADE ? 32'h777 : 32'h000);
      if (k == 16) checkVal("trans16_color", 32'(color), FADE ? 32'h333 : 32'h000);
      if (k == 31) checkVal("trans31_color", 32'(color), FADE ? 32'h111 : 32'h000);
    end
    checkVal("lv1_lvSel",      32'(lvSel),      32'd1);
    checkVal("lv1_lvRst",      32'(lvRst),      32'h2);
    checkVal("lv1_topColor",   32'(topColor),   32'h0F0);
    checkVal("lv1_midColor",   32'(midColor),   32'h080);
    checkVal("lv1_playFrames", 32'(playFrames), 32'd0);
    checkVal("lv1_color",      32'(color),      32'h5A3);

    finishLevel(1);
    finishLevel(2);
    finishLevel(3);
    checkVal("done_color", 32'(color), 32'hCCC);
    checkVal("done_lvRst", 32'(lvRst), 32'h0);
    checkVal("done_lvSel", 32'(lvSel), 32'd3);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkVal("idle_lvSel",    32'(lvSel),    32'd0);
    checkVal("idle_color",    32'(color),    32'h000);
    checkVal("idle_topColor", 32'(topColor), 32'h00F);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    finishLevel(0);
    finishLevel(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkVal("lv2_trans_lvRst", 32'(lvRst), 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkVal("midreset_lvSel", 32'(lvSel), 32'd0);
    checkVal("midreset_lvRst", 32'(lvRst), 32'h0);
    checkVal("midreset_color", 32'(color), 32'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    repeat (70000) applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
    checkVal("saturate_playFrames", 32'(playFrames), 32'h0000FFFF);

    randColor = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (6000) begin
      rA  = ($urandom_range(0, 1999) != 0);
      spA = ($urandom_range(0, 7) == 0);
      irA = 1'($urandom_range(0, 1));
      for (int b = 0; b < NUM_LV; b++) cpA[b] = ($urandom_range(0, 39) == 0);
      applyStimulus(rA, spA, irA, cpA);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
